// File: rtl/apb_evt_pkg.sv
// Shared definitions for the APB event completer:
// event bases, register offsets, decode/state enums and saturating add.
package apb_evt_pkg;

  localparam logic [15:0] BASE_A  = 16'hABBA;
  localparam logic [15:0] BASE_B  = 16'hBAFF;
  localparam logic [15:0] BASE_C  = 16'hCAFE;
  localparam logic [15:0] OFS_TOT = 16'h0000;
  localparam logic [15:0] OFS_CNT = 16'h0004;

  typedef enum logic [1:0] {
    EV_A,
    EV_B,
    EV_C,
    EV_NONE
  } ev_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic ev_sel_t ev_decode(input logic [31:0] addr);
    ev_sel_t sel;
    sel = EV_NONE;
    if (addr[15:0] == OFS_TOT || addr[15:0] == OFS_CNT) begin
      unique case (addr[31:16])
        BASE_A:  sel = EV_A;
        BASE_B:  sel = EV_B;
        BASE_C:  sel = EV_C;
        default: sel = EV_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_evt_regfile.sv
// Per-event running total and transaction count, both saturating.
// Ports: clk/reset, add_en+add_val accumulate, clr_en clears, total/txn_cnt out.
module apb_evt_regfile
  import apb_evt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        add_en,
  input  logic [31:0] add_val,
  input  logic        clr_en,
  output logic [31:0] total,
  output logic [31:0] txn_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total   <= '0;
      txn_cnt <= '0;
    end else if (clr_en) begin
      total   <= '0;
      txn_cnt <= '0;
    end else if (add_en) begin
      total   <= sat_add(total, add_val);
      txn_cnt <= sat_add(txn_cnt, 32'd1);
    end
  end

endmodule

// File: rtl/apb_event_completer.sv
// APB completer accumulating event counts at three event bases.
// Ports: APB completer bus, wait_cfg_i wait states, totals, sticky proto_err_o.
module apb_event_completer
  import apb_evt_pkg::*;
#(
  parameter int MAX_WAIT = 9,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              apb_psel_i,
  input  logic              apb_penable_i,
  input  logic [31:0]       apb_paddr_i,
  input  logic              apb_pwrite_i,
  input  logic [31:0]       apb_pwdata_i,
  output logic              apb_pready_o,
  output logic [31:0]       apb_prdata_o,
  output logic              apb_pslverr_o,
  input  logic [WAIT_W-1:0] wait_cfg_i,
  output logic [31:0]       total_a_o,
  output logic [31:0]       total_b_o,
  output logic [31:0]       total_c_o,
  output logic              proto_err_o
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] cnt_q;
  ev_sel_t           sel_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              proto_q;

  logic              bus_acc;
  logic              bus_setup;
  logic              changed;
  logic              ready;
  logic              latch_en;
  logic              proto_set;
  ev_sel_t           sel_in;
  logic [31:0]       rd_val;

  logic [31:0]       tot [3];
  logic [31:0]       txn [3];
  logic [2:0]        add_en;
  logic [2:0]        clr_en;

  assign bus_acc   = apb_psel_i & apb_penable_i;
  assign bus_setup = apb_psel_i & ~apb_penable_i;
  assign changed   = (apb_paddr_i != addr_q)
                   | (apb_pwrite_i != write_q)
                   | (write_q & (apb_pwdata_i != wdata_q));
  assign sel_in    = ev_decode(apb_paddr_i);

  always_comb begin
    rd_val = '0;
    unique case (sel_in)
      EV_A:    rd_val = apb_paddr_i[2] ? txn[0] : tot[0];
      EV_B:    rd_val = apb_paddr_i[2] ? txn[1] : tot[1];
      EV_C:    rd_val = apb_paddr_i[2] ? txn[2] : tot[2];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   state_nxt = bus_setup ? SETUP : IDLE;
      SETUP:  state_nxt = bus_acc ? ACCESS : IDLE;
      ACCESS: begin
        if (!bus_acc)             state_nxt = IDLE;
        else if (cnt_q == wait_q) state_nxt = DONE;
        else                      state_nxt = ACCESS;
      end
      DONE:   state_nxt = bus_setup ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    latch_en  = 1'b0;
    proto_set = 1'b0;
    unique case (state)
      IDLE:   proto_set = bus_acc;
      SETUP: begin
        latch_en  = bus_acc;
        proto_set = ~bus_acc;
      end
      ACCESS: begin
        ready     = bus_acc & (cnt_q == wait_q);
        proto_set = ~bus_acc | changed;
      end
      DONE:   proto_set = bus_acc;
      default: ;
    endcase
  end

  // Bus fields are captured in SETUP; ACCESS only compares against them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= EV_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      proto_q <= proto_q | proto_set;
      if (latch_en) begin
        addr_q  <= apb_paddr_i;
        wdata_q <= apb_pwdata_i;
        write_q <= apb_pwrite_i;
        wait_q  <= (wait_cfg_i > WAIT_MAX) ? WAIT_MAX : wait_cfg_i;
        cnt_q   <= '0;
        sel_q   <= sel_in;
        rdata_q <= apb_pwrite_i ? 32'd0 : rd_val;
        err_q   <= (sel_in == EV_NONE);
      end else if (state == ACCESS && bus_acc && !ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign apb_pready_o  = ready;
  assign apb_prdata_o  = ready ? rdata_q : 32'd0;
  assign apb_pslverr_o = ready & err_q;
  assign proto_err_o   = proto_q;

  for (genvar i = 0; i < 3; i++) begin : g_ev
    logic hit;
    assign hit = ready & write_q & (sel_q == ev_sel_t'(2'(i)));
    assign add_en[i] = hit & ~addr_q[2];
    assign clr_en[i] = hit & addr_q[2];

    apb_evt_regfile u_rf (
      .clk     (clk),
      .reset   (reset),
      .add_en  (add_en[i]),
      .add_val (wdata_q),
      .clr_en  (clr_en[i]),
      .total   (tot[i]),
      .txn_cnt (txn[i])
    );
  end

  assign total_a_o = tot[0];
  assign total_b_o = tot[1];
  assign total_c_o = tot[2];

endmodule

// File: tb/tb_apb_event_completer.sv
// Self-checking bench for apb_event_completer:
// directed vector table, random transfers vs. a reference model, corner sequences.
module tb_apb_event_completer;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [3:0]  wait_cfg;
  logic [31:0] total_a;
  logic [31:0] total_b;
  logic [31:0] total_c;
  logic        proto_err;

  always #5 clk = ~clk;

  apb_event_completer #(.MAX_WAIT(9), .WAIT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .apb_psel_i    (psel),
    .apb_penable_i (penable),
    .apb_paddr_i   (paddr),
    .apb_pwrite_i  (pwrite),
    .apb_pwdata_i  (pwdata),
    .apb_pready_o  (pready),
    .apb_prdata_o  (prdata),
    .apb_pslverr_o (pslverr),
    .wait_cfg_i    (wait_cfg),
    .total_a_o     (total_a),
    .total_b_o     (total_b),
    .total_c_o     (total_c),
    .proto_err_o   (proto_err)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_tot [3];
  logic [31:0] m_cnt [3];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  wc;
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic [31:0] ta;
    logic [31:0] tb;
    logic [31:0] tc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] a);
    logic [15:0] ofs;
    ofs = a[15:0];
    if (ofs != 16'h0 && ofs != 16'h4) return -1;
    case (a[31:16])
      16'hABBA: return 0;
      16'hBAFF: return 1;
      16'hCAFE: return 2;
      default:  return -1;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_tot[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic m_apply(input logic [31:0] a, input logic wr,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
    int k;
    longint unsigned sum;
    k = m_idx(a);
    rd = 0;
    err = (k < 0);
    if (k >= 0) begin
      if (!wr) begin
        rd = (a[3:0] == 4'h4) ? m_cnt[k] : m_tot[k];
      end else if (a[3:0] == 4'h4) begin
        m_tot[k] = 0;
        m_cnt[k] = 0;
      end else begin
        sum = longint'(m_tot[k]) + longint'(wd);
        m_tot[k] = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
        if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  // lat = number of penable-high cycles up to and including pready
  task automatic apb_xfer(input logic [31:0] a, input logic wr,
                          input logic [31:0] wd, input logic [3:0] wc,
                          output logic [31:0] rd, output logic err,
                          output int lat);
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = a;
    pwrite = wr; pwdata = wd; wait_cfg = wc;
    @(posedge clk); #1;
    penable = 1;
    lat = 0; rd = 0; err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pready) begin
        lat = i + 1;
        rd = prdata;
        err = pslverr;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: no pready for addr %h", a);
    end
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
  endtask

  task automatic run_xfer(input string nm, input logic [31:0] a,
                          input logic wr, input logic [31:0] wd,
                          input logic [3:0] wc, input logic [31:0] e_rd,
                          input logic e_err, input int e_lat);
    logic [31:0] rd, mrd;
    logic err, merr;
    int lat;
    apb_xfer(a, wr, wd, wc, rd, err, lat);
    m_apply(a, wr, wd, mrd, merr);
    check({nm, " lat"}, lat, e_lat);
    check({nm, " slverr"}, {31'd0, err}, {31'd0, e_err});
    if (!wr || e_err) check({nm, " rdata"}, rd, e_rd);
  endtask

  initial begin
    logic [31:0] bases [4];
    logic [31:0] ofs3 [3];
    logic [31:0] a, wd, e_rd;
    logic [31:0] sa, sb, sc;
    logic wr, e_err;
    logic [3:0] wc;
    int e_lat;

    vecs[0]  = '{32'hABBA0000, 1, 32'd3,        0,  0, 0, 2,  3, 0, 0};
    vecs[1]  = '{32'hABBA0004, 0, 32'd0,        0,  1, 0, 2,  3, 0, 0};
    vecs[2]  = '{32'hCAFE0000, 1, 32'd5,        4,  0, 0, 6,  3, 0, 5};
    vecs[3]  = '{32'hCAFE0000, 1, 32'd7,        4,  0, 0, 6,  3, 0, 12};
    vecs[4]  = '{32'hCAFE0000, 0, 32'd0,        0, 12, 0, 2,  3, 0, 12};
    vecs[5]  = '{32'hBAFF0000, 1, 32'h10,      15,  0, 0, 11, 3, 32'h10, 12};
    vecs[6]  = '{32'hBAFF0000, 0, 32'd0,       15, 32'h10, 0, 11, 3, 32'h10, 12};
    vecs[7]  = '{32'hBAFF0004, 1, 32'h55,       0,  0, 0, 2,  3, 0, 12};
    vecs[8]  = '{32'hBAFF0000, 1, 32'hFFFFFFF0, 0,  0, 0, 2,  3, 32'hFFFFFFF0, 12};
    vecs[9]  = '{32'hBAFF0000, 1, 32'h20,       0,  0, 0, 2,  3, 32'hFFFFFFFF, 12};
    vecs[10] = '{32'hBAFF0000, 0, 32'd0,        0, 32'hFFFFFFFF, 0, 2, 3, 32'hFFFFFFFF, 12};
    vecs[11] = '{32'hBAFF0004, 0, 32'd0,        0,  2, 0, 2,  3, 32'hFFFFFFFF, 12};
    vecs[12] = '{32'hBAFF0004, 1, 32'd9,        0,  0, 0, 2,  3, 0, 12};
    vecs[13] = '{32'hBAFF0004, 0, 32'd0,        0,  0, 0, 2,  3, 0, 12};
    vecs[14] = '{32'h12340000, 1, 32'd77,       0,  0, 1, 2,  3, 0, 12};
    vecs[15] = '{32'h12340000, 0, 32'd0,        3,  0, 1, 5,  3, 0, 12};
    vecs[16] = '{32'hABBA0008, 0, 32'd0,        0,  0, 1, 2,  3, 0, 12};

    reset = 1; psel = 0; penable = 0; paddr = 0;
    pwrite = 0; pwdata = 0; wait_cfg = 0;
    m_reset();
    @(negedge clk);
    check("rst pready", {31'd0, pready}, 0);
    check("rst prdata", prdata, 0);
    check("rst pslverr", {31'd0, pslverr}, 0);
    check("rst proto", {31'd0, proto_err}, 0);
    check("rst tot_a", total_a, 0);
    check("rst tot_b", total_b, 0);
    check("rst tot_c", total_c, 0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 17; i++) begin
      run_xfer($sformatf("v%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wd,
               vecs[i].wc, vecs[i].rd, vecs[i].err, vecs[i].lat);
      check($sformatf("v%0d tot_a", i), total_a, vecs[i].ta);
      check($sformatf("v%0d tot_b", i), total_b, vecs[i].tb);
      check($sformatf("v%0d tot_c", i), total_c, vecs[i].tc);
    end

    bases[0] = 32'hABBA0000;
    bases[1] = 32'hBAFF0000;
    bases[2] = 32'hCAFE0000;
    bases[3] = 32'h12340000;
    ofs3[0] = 32'h0;
    ofs3[1] = 32'h4;
    ofs3[2] = 32'h8;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] sv_tot [3];
      logic [31:0] sv_cnt [3];
      a = bases[$urandom_range(0, 3)] | ofs3[$urandom_range(0, 2)];
      if (a[3:0] == 4'h4) wr = ($urandom_range(0, 5) == 0);
      else wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) wd = 32'hF000_0000 | $urandom;
      else wd = $urandom_range(0, 1000);
      wc = 4'($urandom_range(0, 15));
      e_lat = ((wc > 9) ? 9 : int'(wc)) + 2;
      sv_tot = m_tot;
      sv_cnt = m_cnt;
      m_apply(a, wr, wd, e_rd, e_err);
      m_tot = sv_tot;
      m_cnt = sv_cnt;
      run_xfer($sformatf("r%0d", i), a, wr, wd, wc, e_rd, e_err, e_lat);
      check($sformatf("r%0d tot_a", i), total_a, m_tot[0]);
      check($sformatf("r%0d tot_b", i), total_b, m_tot[1]);
      check($sformatf("r%0d tot_c", i), total_c, m_tot[2]);
    end

    check("no proto yet", {31'd0, proto_err}, 0);

    // penable without a setup phase
    sa = total_a; sb = total_b; sc = total_c;
    @(posedge clk); #1;
    psel = 1; penable = 1; paddr = 32'hABBA0000; pwrite = 1; pwdata = 5;
    @(negedge clk);
    check("nosetup pready", {31'd0, pready}, 0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
    check("nosetup proto", {31'd0, proto_err}, 1);
    check("nosetup tot_a", total_a, m_tot[0]);
    run_xfer("post proto", 32'hCAFE0004, 0, 0, 0, m_cnt[2], 0, 2);
    check("proto sticky", {31'd0, proto_err}, 1);
    check("proto tot_a", total_a, sa);
    check("proto tot_b", total_b, sb);
    check("proto tot_c", total_c, sc);

    // reset during the wait of a write
    @(posedge clk); #1;
    psel = 1; penable = 0; paddr = 32'hABBA0000;
    pwrite = 1; pwdata = 9; wait_cfg = 9;
    @(posedge clk); #1;
    penable = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1; psel = 0; penable = 0;
    @(negedge clk);
    m_reset();
    check("midrst pready", {31'd0, pready}, 0);
    check("midrst tot_a", total_a, 0);
    check("midrst proto", {31'd0, proto_err}, 0);
    @(posedge clk); #1;
    reset = 0;
    run_xfer("after rst wr", 32'hABBA0000, 1, 32'd4, 0, 0, 0, 2);
    check("after rst tot_a", total_a, 4);
    run_xfer("after rst rd", 32'hABBA0004, 0, 0, 0, 1, 0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_event_completer.md
Name: apb_event_completer

Overview:
- APB completer (slave) that terminates the APB write stream produced by the events-to-APB initiator.
- Decodes the three event addresses (0xABBA0000 / 0xBAFF0000 / 0xCAFE0000) and accumulates the reported per-event counts into running totals.
- Exposes the totals and transaction counts via APB reads and side-band outputs.
- Inserts a configurable number of wait states (bounded so PREADY arrives within 10 access cycles) and flags unmapped accesses and protocol violations.

Parameters:
- MAX_WAIT, 9, upper clamp on inserted wait states; PREADY is asserted no later than access cycle MAX_WAIT+1.
- WAIT_W, 4, width of wait_cfg_i.

Ports:
- clk  in  1  clock, posedge
- reset  in  1  asynchronous, active-high reset
- apb_psel_i  in  1  APB select
- apb_penable_i  in  1  APB enable
- apb_paddr_i  in  32  APB address
- apb_pwrite_i  in  1  1 = write, 0 = read
- apb_pwdata_i  in  32  write data (event count since last write)
- apb_pready_o  out  1  transfer complete
- apb_prdata_o  out  32  read data, valid when pready_o is high and the access is a read
- apb_pslverr_o  out  1  error response, valid only with pready_o
- wait_cfg_i  in  WAIT_W  wait states to insert, sampled in SETUP
- total_a_o / total_b_o / total_c_o  out  32 each  accumulated event totals
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async):
  - FSM = IDLE; all totals and transaction counts = 0; wait counter = 0.
  - pready_o = 0, prdata_o = 0, pslverr_o = 0, proto_err_o = 0.
  - Reset asserted mid-transfer aborts it; no register update occurs.
- Register map (offset on base 0xABBA0000, 0xBAFF0000 or 0xCAFE0000):
  - +0x0 write: total_x += pwdata, saturating at 0xFFFFFFFF; txn_cnt_x += 1, saturating.
  - +0x0 read: returns total_x.
  - +0x4 read: returns txn_cnt_x.
  - +0x4 write: clears total_x and txn_cnt_x; pwdata is ignored.
  - Any other address is unmapped: completes with pslverr_o = 1, prdata_o = 0, no state change.
- FSM states:
  - IDLE: psel_i & !penable_i -> SETUP. psel_i & penable_i -> set proto_err_o, stay IDLE, no pready_o.
  - SETUP: latch paddr, pwrite, pwdata and wait = min(wait_cfg_i, MAX_WAIT); clear the wait counter; go to ACCESS. penable_i low in the following cycle -> set proto_err_o, return to IDLE.
  - ACCESS:
    - Requires psel_i & penable_i; if either drops -> set proto_err_o, go to IDLE, no update.
    - Changes in paddr, pwrite or pwdata during ACCESS -> set proto_err_o; the latched values are still used.
    - wait counter == wait -> pready_o = 1 (combinational from state and counter) and the register update commits on that clock edge -> DONE. Otherwise the counter increments.
  - DONE: one cycle, pready_o = 0.
    - psel_i & !penable_i -> SETUP (back-to-back transfer).
    - psel_i & penable_i -> set proto_err_o and go to IDLE (missing setup phase).
    - else -> IDLE.
- Latency: wait = N -> pready_o is asserted in the (N+1)th ACCESS cycle. N = 0 gives a zero-wait transfer (SETUP + 1 ACCESS cycle).
- prdata_o and pslverr_o are registered at the SETUP->ACCESS edge (decode of the latched address) and are held 0 outside pready_o.
- A read and the write-clear of the same event cannot coincide (one transfer at a time). Saturation takes priority over wrap: no wrap-around ever.
- proto_err_o is cleared only by reset.

Decomposition:
- Shared package (apb_evt_pkg): the three event base addresses, offsets 0x0 / 0x4, an address-decode enum (EV_A, EV_B, EV_C, EV_NONE), the FSM state enum (IDLE, SETUP, ACCESS, DONE), and a sat_add function.
- One natural sub-module: apb_evt_regfile. It holds the per-event total/count pair with a saturating add and a clear, and is instantiated three times. The FSM and decode stay in the top level.

Test Plan:
- Write 3 to 0xABBA0000 with wait_cfg = 0 -> pready_o in the first ACCESS cycle, pslverr_o = 0, total_a_o = 3; read 0xABBA0004 returns 1.
- Writes of 5 then 7 to 0xCAFE0000 with wait_cfg = 4 -> pready_o high exactly in ACCESS cycle 5 each time; total_c_o = 12; totals A and B unchanged.
- wait_cfg = 15 -> clamped to 9; pready_o arrives in ACCESS cycle 10; read 0xBAFF0000 afterwards returns the expected total.
- Write 0xFFFFFFF0 then 0x20 to 0xBAFF0000 -> total_b_o = 0xFFFFFFFF (saturated); write to 0xBAFF0004 -> total_b_o = 0 and read of +0x4 returns 0.
- Access to 0x12340000 -> pready_o with pslverr_o = 1, all totals unchanged. psel & penable without setup -> proto_err_o = 1 and stays 1 until reset.
- Assert reset during the ACCESS wait of a write of 9 to 0xABBA0000 -> pready_o = 0 immediately, total_a_o = 0 after reset; the next clean transfer completes normally.
